// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared parameters and helpers for the instruction fetch stage.
//   DEF_ADDR_SIZE   : default code address width
//   DEF_WORD_SIZE   : default instruction word width
//   DEF_QUEUE_DEPTH : default prefetch queue depth (power of two, >= 2)
//   count_width()   : bits needed to hold an occupancy of 0..depth inclusive
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int DEF_ADDR_SIZE   = 18;
    localparam int DEF_WORD_SIZE   = 18;
    localparam int DEF_QUEUE_DEPTH = 4;

    // Occupancy counter must represent "full" (== depth), hence the extra bit.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the code-memory read port, the core redirect port and the
// instruction hand-off handshake of the fetch stage.
//   mem_rd/mem_addr     : read strobe and address toward code memory
//   mem_data            : read data, valid the cycle after mem_rd
//   jump/jump_addr      : single-cycle redirect from the core
//   instr_valid/instr/instr_addr/instr_ready : instruction hand-off
// Modports:
//   master : the fetch unit side
//   slave  : the environment side (code memory + core)
// -----------------------------------------------------------------------------
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE
);
    logic                 mem_rd;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 jump;
    logic [ADDR_SIZE-1:0] jump_addr;
    logic                 instr_valid;
    logic [WORD_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] instr_addr;
    logic                 instr_ready;

    modport master (
        output mem_rd, mem_addr, instr_valid, instr, instr_addr,
        input  mem_data, jump, jump_addr, instr_ready
    );

    modport slave (
        input  mem_rd, mem_addr, instr_valid, instr, instr_addr,
        output mem_data, jump, jump_addr, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO holding {word, addr} prefetch entries.
//   clock, reset : clock and synchronous active-high reset (empties the queue)
//   i_push/i_data: write an entry at the tail
//   i_pop        : remove the head (ignored when empty)
//   i_flush      : discard all entries; wins over a simultaneous push
//   o_data       : current head entry (don't-care when o_count == 0)
//   o_count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = DEF_QUEUE_DEPTH,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_write;

    assign w_do_pop   = i_pop && (r_count != '0);
    assign w_do_write = i_push && !i_flush && !reset;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clock) begin
        if (w_do_write) begin
            r_mem[r_tail] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // The upstream credit check must make a push into a full queue impossible.
            assert (!(i_push && (r_count == CW'(DEPTH))));
            if (i_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage in front of the decode/execute core. Owns the fetch
// pointer, issues reads to 1-cycle-latency code memory, buffers returned
// words with their addresses in fetch_queue and hands them to the core.
//   clock : system clock
//   reset : synchronous, active-high; discards queue and any in-flight read
//   bus   : fetch_unit_if.master (memory read port, jump port, instr handshake)
// A jump flushes everything at the edge; no read is issued in the jump cycle.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int CW = count_width(QUEUE_DEPTH);
    localparam int QW = ADDR_SIZE + WORD_SIZE;

    logic [ADDR_SIZE-1:0] r_fetch_ip;
    logic                 r_inflight;
    logic [ADDR_SIZE-1:0] r_inflight_addr;

    logic [CW-1:0]        w_count;
    logic [CW:0]          w_pending;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [QW-1:0]        w_head;

    // Credit: entries already queued plus the one possibly returning next
    // cycle must leave room, so a returning word always finds a free slot.
    assign w_pending = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue   = !reset && !bus.jump && (w_pending < (CW+1)'(QUEUE_DEPTH));

    // Data returning in a jump cycle belongs to the abandoned stream.
    assign w_push = r_inflight && !bus.jump;
    assign w_pop  = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_ip      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else if (bus.jump) begin
            r_fetch_ip <= bus.jump_addr;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_ip      <= r_fetch_ip + ADDR_SIZE'(1);
                r_inflight_addr <= r_fetch_ip;
            end
        end
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.jump),
        .i_data  ({bus.mem_data, r_inflight_addr}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.mem_rd      = w_issue;
    assign bus.mem_addr    = r_fetch_ip;
    assign bus.instr_valid = (w_count != '0);
    assign bus.instr       = w_head[QW-1:ADDR_SIZE];
    assign bus.instr_addr  = w_head[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit through directed scenarios and a randomized run. A
// queue-level reference model predicts mem_rd/mem_addr and the instruction
// head every cycle; literal expectations pin down the headline timing.
// Code memory: word[a] = a + 100 (mod 2^WORD_SIZE), 1-cycle read latency.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    localparam int A = 18;
    localparam int W = 18;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] w;
        logic [A-1:0] a;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_unit_if #(.ADDR_SIZE(A), .WORD_SIZE(W)) bus ();

    fetch_unit #(.ADDR_SIZE(A), .WORD_SIZE(W), .QUEUE_DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [W-1:0] word_of(input logic [A-1:0] a);
        return W'(32'(a) + 32'd100);
    endfunction

    // Synchronous code memory; garbage on the bus when not reading.
    always @(posedge clock) begin
        bus.mem_data <= bus.mem_rd ? word_of(bus.mem_addr) : W'($urandom);
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t         m_q[$];
    bit           m_infl  = 1'b0;
    logic [A-1:0] m_infl_addr = '0;
    logic [A-1:0] m_ip = '0;
    bit           m_known = 1'b0;

    // Observation logs (cleared per scenario)
    ent_t         got[$];
    logic [A-1:0] rd_log[$];
    bit           valid_log[$];
    ent_t         head_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic missing(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=<no entry> required=<entry> t=%0t", name, $time);
    endtask

    task automatic chk_got(input string name, input int k, input logic [A-1:0] a);
        if (k < got.size()) check(name, 64'(got[k]), 64'({word_of(a), a}));
        else missing(name);
    endtask

    task automatic chk_rd(input string name, input int k, input logic [A-1:0] a);
        if (k < rd_log.size()) check(name, 64'(rd_log[k]), 64'(a));
        else missing(name);
    endtask

    task automatic chk_valid(input string name, input int k, input bit v);
        if (k < valid_log.size()) check(name, 64'(valid_log[k]), 64'(v));
        else missing(name);
    endtask

    task automatic clear_logs();
        got.delete();
        rd_log.delete();
        valid_log.delete();
        head_log.delete();
    endtask

    // One clock cycle: compare at negedge, advance model at posedge,
    // then leave 1 time unit for the caller to change inputs.
    task automatic step();
        bit exp_rd;
        bit consumed;
        @(negedge clock);
        exp_rd = !reset && !bus.jump && ((m_q.size() + int'(m_infl)) < D);
        check("mem_rd", 64'(bus.mem_rd), 64'(exp_rd));
        if (exp_rd) check("mem_addr", 64'(bus.mem_addr), 64'(m_ip));
        if (m_known) begin
            check("instr_valid", 64'(bus.instr_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("instr", 64'(bus.instr), 64'(m_q[0].w));
                check("instr_addr", 64'(bus.instr_addr), 64'(m_q[0].a));
            end
        end
        valid_log.push_back(bus.instr_valid);
        head_log.push_back({bus.instr, bus.instr_addr});
        if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
        if (bus.instr_valid && bus.instr_ready) got.push_back({bus.instr, bus.instr_addr});
        $display("cyc t=%0t rst=%0b jmp=%0b rdy=%0b rd=%0b addr=%0h valid=%0b instr=%0h iaddr=%0h",
                 $time, reset, bus.jump, bus.instr_ready, bus.mem_rd, bus.mem_addr,
                 bus.instr_valid, bus.instr, bus.instr_addr);
        @(posedge clock);
        if (reset) begin
            m_q.delete();
            m_infl  = 1'b0;
            m_ip    = '0;
            m_known = 1'b1;
        end else if (bus.jump) begin
            m_q.delete();
            m_infl = 1'b0;
            m_ip   = bus.jump_addr;
        end else begin
            consumed = (m_q.size() != 0) && bus.instr_ready;
            if (consumed) void'(m_q.pop_front());
            if (m_infl) m_q.push_back({word_of(m_infl_addr), m_infl_addr});
            m_infl = exp_rd;
            if (exp_rd) begin
                m_infl_addr = m_ip;
                m_ip        = m_ip + A'(1);
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int mode;
        bus.jump        = 1'b0;
        bus.jump_addr   = '0;
        bus.instr_ready = 1'b1;
        reset           = 1'b1;
        run(3);

        // Reset release with ready held high: stream from cycle 0.
        reset = 1'b0;
        clear_logs();
        run(8);
        chk_rd("p1_addr_c0", 0, 18'd0);
        chk_rd("p1_addr_c2", 2, 18'd2);
        chk_valid("p1_valid_c1", 1, 1'b0);
        chk_valid("p1_valid_c2", 2, 1'b1);
        chk_got("p1_first", 0, 18'd0);
        chk_got("p1_second", 1, 18'd1);
        chk_got("p1_third", 2, 18'd2);
        check("p1_rate", 64'(got.size()), 64'd6);

        // Stall from reset: exactly DEPTH reads, then drain and resume at 4.
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        bus.instr_ready = 1'b0;
        clear_logs();
        run(8);
        check("p2_reads", 64'(rd_log.size()), 64'd4);
        chk_rd("p2_last_addr", 3, 18'd3);
        bus.instr_ready = 1'b1;
        clear_logs();
        run(8);
        for (int k = 0; k < 4; k++) chk_got("p2_drain", k, A'(k));
        chk_rd("p2_resume", 0, 18'd4);

        // Jump with 3 queued and a read in flight.
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        bus.instr_ready = 1'b0;
        run(4);
        bus.jump      = 1'b1;
        bus.jump_addr = 18'h200;
        run(1);
        bus.jump      = 1'b0;
        bus.jump_addr = 18'h0abc;
        clear_logs();
        run(3);
        chk_valid("p3_valid_j1", 0, 1'b0);
        chk_rd("p3_target", 0, 18'h200);
        chk_valid("p3_valid_j3", 2, 1'b1);
        if (head_log.size() > 2) check("p3_head", 64'(head_log[2]), 64'({word_of(18'h200), 18'h200}));
        else missing("p3_head");

        // Jump and pop in the same cycle.
        bus.instr_ready = 1'b1;
        bus.jump        = 1'b1;
        bus.jump_addr   = 18'h1234;
        clear_logs();
        run(1);
        bus.jump = 1'b0;
        run(3);
        chk_got("p4_popped", 0, 18'h200);
        chk_valid("p4_empty", 1, 1'b0);
        chk_rd("p4_target", 0, 18'h1234);
        chk_got("p4_restart", 1, 18'h1234);

        // Jump to the top of the address space: pointer wraps.
        bus.jump      = 1'b1;
        bus.jump_addr = 18'h3ffff;
        run(1);
        bus.jump = 1'b0;
        clear_logs();
        run(6);
        chk_got("p5_top", 0, 18'h3ffff);
        chk_got("p5_wrap0", 1, 18'h00000);
        chk_got("p5_wrap1", 2, 18'h00001);

        // Reset with full queue and read in flight.
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        bus.instr_ready = 1'b0;
        run(4);
        reset = 1'b1;
        clear_logs();
        run(2);
        chk_valid("p6_valid", 1, 1'b0);
        check("p6_no_reads", 64'(rd_log.size()), 64'd0);
        reset = 1'b0;
        clear_logs();
        run(1);
        chk_rd("p6_restart", 0, 18'd0);

        // Randomized traffic with stall bursts, jumps near the wrap point, resets.
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 64) == 0) mode = int'($urandom_range(0, 2));
            reset = ($urandom_range(0, 249) == 0);
            case (mode)
                0:       bus.instr_ready = 1'b1;
                1:       bus.instr_ready = ($urandom_range(0, 3) != 0);
                default: bus.instr_ready = ($urandom_range(0, 7) == 0);
            endcase
            bus.jump = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) bus.jump_addr = A'(32'h40000 - $urandom_range(1, 3));
            else bus.jump_addr = A'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
